// File: rtl/selector41_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : selector41_arbiter_pkg
// Description : Shared types and constants for the selector41 round-robin
//               arbiter: FSM state encoding, requester count, select width
//               and a one-hot decode helper.
// Revision    : 1.0 - initial release
// ============================================================================
package selector41_arbiter_pkg;

    // Number of requesters sharing the 4:1 mux.
    localparam int NREQ  = 4;
    // Width of the mux select / owner index.
    localparam int SEL_W = 2;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    // Owner index to one-hot grant vector.
    function automatic logic [NREQ-1:0] onehot4(input logic [SEL_W-1:0] idx);
        logic [NREQ-1:0] v;
        v = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage : selector41_arbiter_pkg
`default_nettype wire

// File: rtl/selector41_arbiter_rr_pick4.sv
`default_nettype none
// ============================================================================
// Module      : rr_pick4
// Description : Combinational rotate-priority picker. Scans req starting at
//               bit ptr and wrapping modulo 4; returns the first set bit.
//   req [3:0] : request vector
//   ptr [1:0] : highest-priority position for this scan
//   any       : at least one request is set
//   idx [1:0] : index of the winning request (0 when any=0)
// Revision    : 1.0 - initial release
// ============================================================================
module rr_pick4
    import selector41_arbiter_pkg::*;
(
    input  logic [NREQ-1:0]  req,
    input  logic [SEL_W-1:0] ptr,
    output logic             any,
    output logic [SEL_W-1:0] idx
);

    logic [SEL_W-1:0] w_cand;

    // Walk from the farthest offset back to ptr so the nearest set bit
    // (lowest offset from ptr) is the last one written and therefore wins.
    always_comb begin
        any    = |req;
        idx    = '0;
        w_cand = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            w_cand = ptr + SEL_W'(i);
            if (req[w_cand]) begin
                idx = w_cand;
            end
        end
    end

endmodule : rr_pick4
`default_nettype wire

// File: rtl/selector41_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : selector41_arbiter
// Description : Round-robin arbiter sharing one selector41 4:1 mux among four
//               requesters, with a bounded hold time per grant.
//   iClk       : clock, rising edge
//   iRst       : asynchronous active-high reset
//   iReq [3:0] : request vector, bit n wants mux input iCn
//   oGnt [3:0] : one-hot grant, zero when idle
//   oValid     : a grant is active
//   oS1/oS0    : mux select, drives selector41 iS1/iS0
//   oOwner[1:0]: current or last owner, equals {oS1,oS0}
// Parameters  : MAX_HOLD - max consecutive granted cycles (0 = unlimited)
//               CNT_W    - hold counter width, 2**CNT_W > MAX_HOLD
// Revision    : 1.0 - initial release
// ============================================================================
module selector41_arbiter
    import selector41_arbiter_pkg::*;
#(
    parameter int MAX_HOLD = 4,
    parameter int CNT_W    = 8
)(
    input  logic             iClk,
    input  logic             iRst,
    input  logic [NREQ-1:0]  iReq,
    output logic [NREQ-1:0]  oGnt,
    output logic             oValid,
    output logic             oS1,
    output logic             oS0,
    output logic [SEL_W-1:0] oOwner
);

    // Counter value on which the last allowed granted cycle ends.
    localparam logic [CNT_W-1:0] C_HOLD_LAST =
        (MAX_HOLD == 0) ? '0 : CNT_W'(MAX_HOLD - 1);
    localparam logic             C_HOLD_EN   = (MAX_HOLD != 0);

    state_t           state_q;
    logic [SEL_W-1:0] ptr_q;
    logic [SEL_W-1:0] owner_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [NREQ-1:0]  gnt_q;
    logic             valid_q;

    logic             w_pick_any;
    logic [SEL_W-1:0] w_pick_idx;
    logic             w_release;

    rr_pick4 u_pick (
        .req (iReq),
        .ptr (ptr_q),
        .any (w_pick_any),
        .idx (w_pick_idx)
    );

    // Saturating increment: with unlimited hold the counter parks at all-ones
    // rather than wrapping.
    assign cnt_d     = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
    assign w_release = !iReq[owner_q] || (C_HOLD_EN && (cnt_q == C_HOLD_LAST));

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            owner_q <= '0;
            cnt_q   <= '0;
            gnt_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (w_pick_any) begin
                        state_q <= ST_GRANT;
                        owner_q <= w_pick_idx;
                        gnt_q   <= onehot4(w_pick_idx);
                        valid_q <= 1'b1;
                        cnt_q   <= '0;
                    end
                end
                ST_GRANT: begin
                    if (w_release) begin
                        // owner_q is kept so the mux select does not move
                        // during the bubble.
                        state_q <= ST_IDLE;
                        gnt_q   <= '0;
                        valid_q <= 1'b0;
                        ptr_q   <= owner_q + 1'b1;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q   <= cnt_d;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    gnt_q   <= '0;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign oGnt   = gnt_q;
    assign oValid = valid_q;
    assign oOwner = owner_q;
    assign oS1    = owner_q[1];
    assign oS0    = owner_q[0];

endmodule : selector41_arbiter
`default_nettype wire

// File: tb/tb_selector41_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_selector41_arbiter
// Description : Self-checking bench for selector41_arbiter. Two instances
//               share clock, reset and requests: one with MAX_HOLD=4 and one
//               with unlimited hold. Each is compared every cycle against a
//               behavioural round-robin model, plus table-driven sequences
//               and hand-written corner cases.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_selector41_arbiter;

    logic       iClk;
    logic       iRst;
    logic [3:0] iReq;

    logic [3:0] gnt0, gnt1;
    logic       valid0, valid1, s1_0, s0_0, s1_1, s0_1;
    logic [1:0] own0, own1;

    int n_checks = 0;
    int n_errors = 0;

    selector41_arbiter #(.MAX_HOLD(4), .CNT_W(8)) u_dut4 (
        .iClk(iClk), .iRst(iRst), .iReq(iReq),
        .oGnt(gnt0), .oValid(valid0), .oS1(s1_0), .oS0(s0_0), .oOwner(own0)
    );

    selector41_arbiter #(.MAX_HOLD(0), .CNT_W(8)) u_dut0 (
        .iClk(iClk), .iRst(iRst), .iReq(iReq),
        .oGnt(gnt1), .oValid(valid1), .oS1(s1_1), .oS0(s0_1), .oOwner(own1)
    );

    initial iClk = 1'b0;
    always #5 iClk = ~iClk;

    // ---------------- behavioural reference model ----------------
    int m_hold  [2] = '{4, 0};
    bit m_valid [2];
    int m_owner [2];
    int m_ptr   [2];
    int m_held  [2];   // granted cycles elapsed in the current grant

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_valid[k] = 0; m_owner[k] = 0; m_ptr[k] = 0; m_held[k] = 0;
        end
    endtask

    task automatic model_step(input logic [3:0] r);
        for (int k = 0; k < 2; k++) begin
            if (!m_valid[k]) begin
                for (int off = 3; off >= 0; off--) begin
                    if (r[(m_ptr[k] + off) % 4]) m_owner[k] = (m_ptr[k] + off) % 4;
                end
                if (r != 4'b0000) begin
                    m_valid[k] = 1;
                    m_held[k]  = 1;
                end
            end else if (!r[m_owner[k]] || (m_hold[k] != 0 && m_held[k] == m_hold[k])) begin
                m_valid[k] = 0;
                m_ptr[k]   = (m_owner[k] + 1) % 4;
            end else begin
                m_held[k]++;
            end
        end
    endtask

    // ---------------- checking ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_model(input string tag);
        logic [3:0] eg0, eg1;
        eg0 = m_valid[0] ? (4'b0001 << m_owner[0]) : 4'b0000;
        eg1 = m_valid[1] ? (4'b0001 << m_owner[1]) : 4'b0000;
        chk({tag, " hold4 gnt"},   32'(gnt0),          32'(eg0));
        chk({tag, " hold4 valid"}, 32'(valid0),        32'(m_valid[0]));
        chk({tag, " hold4 sel"},   32'({s1_0, s0_0}),  32'(m_owner[0]));
        chk({tag, " hold4 owner"}, 32'(own0),          32'(m_owner[0]));
        chk({tag, " hold0 gnt"},   32'(gnt1),          32'(eg1));
        chk({tag, " hold0 valid"}, 32'(valid1),        32'(m_valid[1]));
        chk({tag, " hold0 sel"},   32'({s1_1, s0_1}),  32'(m_owner[1]));
        chk({tag, " hold0 owner"}, 32'(own1),          32'(m_owner[1]));
    endtask

    // Called at a negedge; drives request, advances one clock, checks #1 after.
    task automatic cycle(input logic [3:0] r, input string tag);
        iReq = r;
        @(posedge iClk);
        model_step(r);
        #1;
        check_model(tag);
        @(negedge iClk);
    endtask

    task automatic do_reset();
        iRst = 1'b1;
        #1;
        model_reset();
        check_model("reset");
        @(posedge iClk);
        @(negedge iClk);
        iRst = 1'b0;
    endtask

    // ---------------- table-driven sequences ----------------
    typedef struct {
        logic [3:0] req;
        logic [3:0] gnt;
        logic       valid;
        logic [1:0] sel;
    } vec_t;

    vec_t tbl_single[6];
    vec_t tbl_all[24];

    function automatic vec_t mk(input logic [3:0] r, input logic v, input int g);
        vec_t x;
        x.req   = r;
        x.valid = v;
        x.sel   = 2'(g);
        x.gnt   = v ? (4'b0001 << g) : 4'b0000;
        return x;
    endfunction

    initial begin
        int row;
        iRst = 1'b1;
        iReq = 4'b0000;

        // Sole requester 2: four granted cycles, one bubble, re-grant.
        for (int i = 0; i < 4; i++) tbl_single[i] = mk(4'b0100, 1, 2);
        tbl_single[4] = mk(4'b0100, 0, 2);
        tbl_single[5] = mk(4'b0100, 1, 2);

        // All requesting: order 0,1,2,3,0, each 4 cycles plus one bubble.
        row = 0;
        for (int g = 0; g < 5; g++) begin
            for (int i = 0; i < 4; i++) begin
                tbl_all[row] = mk(4'b1111, 1, g % 4);
                row++;
            end
            if (g < 4) begin
                tbl_all[row] = mk(4'b1111, 0, g % 4);
                row++;
            end
        end

        @(negedge iClk);

        // 1. Idle after reset.
        do_reset();
        for (int i = 0; i < 10; i++) begin
            cycle(4'b0000, "idle");
            chk("idle gnt", 32'(gnt0), 32'h0);
            chk("idle sel", 32'({s1_0, s0_0}), 32'h0);
        end

        // 2. Single requester 2 with timeout.
        do_reset();
        foreach (tbl_single[i]) begin
            cycle(tbl_single[i].req, "single");
            chk($sformatf("single[%0d] gnt", i),   32'(gnt0),         32'(tbl_single[i].gnt));
            chk($sformatf("single[%0d] valid", i), 32'(valid0),       32'(tbl_single[i].valid));
            chk($sformatf("single[%0d] sel", i),   32'({s1_0, s0_0}), 32'(tbl_single[i].sel));
        end

        // 3. All requesting, round-robin rotation.
        do_reset();
        foreach (tbl_all[i]) begin
            cycle(tbl_all[i].req, "all");
            chk($sformatf("all[%0d] gnt", i),   32'(gnt0),         32'(tbl_all[i].gnt));
            chk($sformatf("all[%0d] valid", i), 32'(valid0),       32'(tbl_all[i].valid));
            chk($sformatf("all[%0d] sel", i),   32'({s1_0, s0_0}), 32'(tbl_all[i].sel));
        end

        // 4. Owner 1 drops its request after 2 cycles while 3 waits.
        do_reset();
        cycle(4'b0010, "drop");
        chk("drop grant1", 32'(gnt0), 32'h2);
        cycle(4'b1010, "drop");
        chk("drop hold1", 32'(gnt0), 32'h2);
        cycle(4'b1000, "drop");
        chk("drop bubble valid", 32'(valid0), 32'h0);
        chk("drop bubble sel", 32'({s1_0, s0_0}), 32'h1);
        cycle(4'b1000, "drop");
        chk("drop next gnt", 32'(gnt0), 32'h8);
        chk("drop next sel", 32'({s1_0, s0_0}), 32'h3);

        // 5. Asynchronous reset mid-grant.
        do_reset();
        cycle(4'b0100, "arst");
        chk("arst pre gnt", 32'(gnt0), 32'h4);
        #2;
        iRst = 1'b1;
        #1;
        model_reset();
        check_model("arst immediate");
        @(posedge iClk);
        #1;
        check_model("arst held");
        @(negedge iClk);
        iRst = 1'b0;
        cycle(4'b0110, "arst after");
        chk("arst after gnt", 32'(gnt0), 32'h2);
        chk("arst after sel", 32'({s1_0, s0_0}), 32'h1);

        // 6. Unlimited hold: requester 0 held 300 cycles, then drop.
        do_reset();
        for (int i = 0; i < 300; i++) begin
            cycle(4'b0001, "nolimit");
            chk("nolimit gnt", 32'(gnt1), 32'h1);
        end
        cycle(4'b0000, "nolimit drop");
        chk("nolimit drop valid", 32'(valid1), 32'h0);
        chk("nolimit drop sel", 32'({s1_1, s0_1}), 32'h0);

        // Randomized traffic, requests tending to persist for a while.
        do_reset();
        begin
            logic [3:0] r;
            r = 4'b0000;
            for (int i = 0; i < 400; i++) begin
                if ($urandom_range(0, 3) == 0) r = 4'($urandom_range(0, 15));
                cycle(r, "random");
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule : tb_selector41_arbiter
`default_nettype wire
